// File: rtl/global_ldst_burst_gen_pkg.sv
// Shared types for the global load/store burst generator: vtype encoding,
// page size and the address-channel request bundle.
package global_ldst_burst_gen_pkg;

    typedef enum logic [2:0] {
        EW8  = 3'd0,
        EW16 = 3'd1,
        EW32 = 3'd2,
        EW64 = 3'd3
    } vew_e;

    typedef struct packed {
        logic       vill;
        logic       vma;
        logic       vta;
        vew_e       vsew;
        logic [2:0] vlmul;
    } vtype_t;

    localparam int unsigned PageBytes = 32'd4096;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic        write;
        logic        last;
    } global_ax_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } burst_state_e;

endpackage

// File: rtl/global_ldst_burst_gen.sv
// Splits a unit-stride vector memory request into AXI address-channel bursts
// that never exceed MaxBurstLen beats nor cross a 4 KiB page.
module global_ldst_burst_gen
    import global_ldst_burst_gen_pkg::*;
#(
    parameter int unsigned NrClusters   = 0,
    parameter type         vlen_cl_t    = logic,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 512,
    parameter int unsigned MaxBurstLen  = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  vlen_cl_t                vl_i,
    input  vtype_t                  vtype_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic                    req_is_store_i,
    output logic                    ax_valid_o,
    input  logic                    ax_ready_i,
    output logic [AxiAddrWidth-1:0] ax_addr_o,
    output logic [7:0]              ax_len_o,
    output logic [2:0]              ax_size_o,
    output logic                    ax_write_o,
    output logic                    ax_last_o,
    output logic                    done_o,
    output logic                    busy_o
);

    localparam int unsigned DB     = AxiDataWidth / 8;
    localparam int unsigned SzBits = $clog2(DB);
    localparam int unsigned RemW   = $bits(vlen_cl_t) + 3;
    // Wide enough for rem + page/offset terms and MaxBurstLen*DB without wrap.
    localparam int unsigned CW     = RemW + 22;

    burst_state_e           state_q;
    logic [AxiAddrWidth-1:0] addr_q;
    logic [RemW-1:0]         rem_q;
    logic                    write_q;
    logic                    done_q;

    logic [RemW-1:0]         req_bytes;
    logic [8:0]              beats;
    logic [CW-1:0]           consumed;
    logic                    last_burst;
    logic                    is_issue;
    global_ax_req_t          ax_req;

    // Beats of the next burst and the payload bytes it covers; divisions are shifts.
    function automatic logic [CW-1:0] burst_calc(
        input  logic [AxiAddrWidth-1:0] addr,
        input  logic [RemW-1:0]         rem,
        output logic [8:0]              nbeats
    );
        logic [CW-1:0] off;
        logic [CW-1:0] need;
        logic [CW-1:0] page;
        logic [CW-1:0] bt;
        logic [CW-1:0] span;
        off    = CW'(addr & AxiAddrWidth'(DB - 1));
        need   = (off + CW'(rem) + CW'(DB - 1)) >> SzBits;
        page   = (CW'(PageBytes) - CW'(addr & AxiAddrWidth'(PageBytes - 1)) + off) >> SzBits;
        bt     = (page < need) ? page : need;
        bt     = (CW'(MaxBurstLen) < bt) ? CW'(MaxBurstLen) : bt;
        nbeats = bt[8:0];
        span   = (bt << SzBits) - off;
        return (CW'(rem) < span) ? CW'(rem) : span;
    endfunction

    // Burst field computation from the registered request state.
    always_comb begin
        beats      = 9'd0;
        is_issue   = (state_q == ISSUE);
        req_bytes  = RemW'(vl_i) << vtype_i.vsew;
        consumed   = burst_calc(addr_q, rem_q, beats);
        last_burst = (consumed == CW'(rem_q));
        ax_req     = '0;
        if (is_issue) begin
            ax_req.addr  = 64'(addr_q);
            ax_req.len   = 8'(beats - 9'd1);
            ax_req.write = write_q;
            ax_req.last  = last_burst;
        end else begin
            ax_req.addr  = 64'd0;
            ax_req.len   = 8'd0;
            ax_req.write = 1'b0;
            ax_req.last  = 1'b0;
        end
        ax_req.size = 3'(SzBits);
    end

    assign ax_valid_o  = is_issue;
    assign busy_o      = is_issue;
    assign req_ready_o = ~is_issue;
    assign done_o      = done_q;
    assign ax_addr_o   = AxiAddrWidth'(ax_req.addr);
    assign ax_len_o    = ax_req.len;
    assign ax_size_o   = ax_req.size;
    assign ax_write_o  = ax_req.write;
    assign ax_last_o   = ax_req.last;

    // Request FSM: snapshot on acceptance, advance one burst per ax handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        write_q <= req_is_store_i;
                        rem_q   <= req_bytes;
                        if (vtype_i.vill || (vl_i == '0)) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (ax_ready_i) begin
                        addr_q <= addr_q + AxiAddrWidth'(consumed);
                        rem_q  <= rem_q - RemW'(consumed);
                        if (last_burst) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_global_ldst_burst_gen.sv
// Bench for global_ldst_burst_gen: two instances (MaxBurstLen 256 and 16) driven
// by the same requests and compared every cycle against a byte-range burst model.
module tb_global_ldst_burst_gen;
    import global_ldst_burst_gen_pkg::*;

    typedef logic [15:0] vl_t;
    localparam int unsigned DB = 64;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic        last;
        logic        write;
    } burst_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    vl_t         vl = '0;
    vtype_t      vtype = '0;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = '0;
    logic        req_store = 1'b0;
    logic        ax_ready = 1'b0;

    logic        rr0, av0, aw0, alst0, dn0, bz0;
    logic [63:0] aa0;
    logic [7:0]  al0;
    logic [2:0]  as0;
    logic        rr1, av1, aw1, alst1, dn1, bz1;
    logic [63:0] aa1;
    logic [7:0]  al1;
    logic [2:0]  as1;

    burst_t q0[$];
    burst_t q1[$];
    bit     due0 = 1'b0;
    bit     due1 = 1'b0;
    int     checks = 0;
    int     errors = 0;
    int     stall_left = 0;
    bit     force_ready = 1'b0;

    always #5 clk = ~clk;

    global_ldst_burst_gen #(.vlen_cl_t(vl_t), .AxiAddrWidth(64), .AxiDataWidth(512), .MaxBurstLen(256)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .vl_i(vl), .vtype_i(vtype),
        .req_valid_i(req_valid), .req_ready_o(rr0), .req_addr_i(req_addr), .req_is_store_i(req_store),
        .ax_valid_o(av0), .ax_ready_i(ax_ready), .ax_addr_o(aa0), .ax_len_o(al0), .ax_size_o(as0),
        .ax_write_o(aw0), .ax_last_o(alst0), .done_o(dn0), .busy_o(bz0)
    );

    global_ldst_burst_gen #(.vlen_cl_t(vl_t), .AxiAddrWidth(64), .AxiDataWidth(512), .MaxBurstLen(16)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_ni), .vl_i(vl), .vtype_i(vtype),
        .req_valid_i(req_valid), .req_ready_o(rr1), .req_addr_i(req_addr), .req_is_store_i(req_store),
        .ax_valid_o(av1), .ax_ready_i(ax_ready), .ax_addr_o(aa1), .ax_len_o(al1), .ax_size_o(as1),
        .ax_write_o(aw1), .ax_last_o(alst1), .done_o(dn1), .busy_o(bz1)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Byte-range model: each burst ends at the earliest of request end, page end
    // and the max-burst window starting at the aligned beat of its start address.
    function automatic void model(int inst, longint unsigned addr, int unsigned vlv,
                                  int unsigned sew, bit vill, bit wr, int unsigned mbl);
        longint unsigned a, rem, base, pend, lim, e;
        burst_t b;
        rem = (vill || vlv == 0) ? 64'd0 : (longint'(vlv) << sew);
        a = addr;
        while (rem > 0) begin
            base = a - (a % DB);
            pend = (a / 4096 + 1) * 4096;
            lim  = base + longint'(mbl) * DB;
            e    = a + rem;
            if (pend < e) e = pend;
            if (lim < e) e = lim;
            b.addr  = a;
            b.len   = 8'((e - base + DB - 1) / DB - 1);
            b.last  = (e == a + rem);
            b.write = wr;
            if (inst == 0) q0.push_back(b);
            else q1.push_back(b);
            rem = rem - (e - a);
            a = e;
        end
    endfunction

    task automatic check_one(input int inst, input logic av, input logic rr, input logic dn,
                             input logic bz, input logic [63:0] aa, input logic [7:0] al,
                             input logic [2:0] as, input logic aw, input logic alst);
        int n;
        bit due;
        burst_t f;
        n   = (inst == 0) ? q0.size() : q1.size();
        due = (inst == 0) ? due0 : due1;
        chk($sformatf("valid%0d", inst), 64'(av), 64'(n > 0));
        chk($sformatf("busy%0d", inst), 64'(bz), 64'(n > 0));
        chk($sformatf("req_ready%0d", inst), 64'(rr), 64'(n == 0));
        chk($sformatf("done%0d", inst), 64'(dn), 64'(due));
        if (n > 0 && av) begin
            f = (inst == 0) ? q0[0] : q1[0];
            chk($sformatf("addr%0d", inst), aa, f.addr);
            chk($sformatf("len%0d", inst), 64'(al), 64'(f.len));
            chk($sformatf("last%0d", inst), 64'(alst), 64'(f.last));
            chk($sformatf("write%0d", inst), 64'(aw), 64'(f.write));
            chk($sformatf("size%0d", inst), 64'(as), 64'd6);
        end
    endtask

    task automatic cycle();
        bit r;
        @(negedge clk);
        check_one(0, av0, rr0, dn0, bz0, aa0, al0, as0, aw0, alst0);
        check_one(1, av1, rr1, dn1, bz1, aa1, al1, as1, aw1, alst1);
        due0 = 1'b0;
        due1 = 1'b0;
        if (stall_left > 0) begin
            r = 1'b0;
            stall_left--;
        end else if (force_ready) begin
            r = 1'b1;
        end else begin
            r = ($urandom_range(0, 3) != 0);
        end
        ax_ready = r;
        if (!req_valid) begin
            vl    = vl_t'($urandom);
            vtype = vtype_t'($urandom);
        end
        if (av0 && r && q0.size() > 0) begin
            if (q0[0].last) due0 = 1'b1;
            void'(q0.pop_front());
        end
        if (av1 && r && q1.size() > 0) begin
            if (q1[0].last) due1 = 1'b1;
            void'(q1.pop_front());
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || due0 || due1) && n < 3000) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL timeout: got %0d cycles expected < 3000", n);
        end
    endtask

    task automatic do_req(input logic [63:0] addr, input int unsigned vlv, input int unsigned sew,
                          input bit vill, input bit wr);
        vl         = vl_t'(vlv);
        vtype      = '0;
        vtype.vsew = vew_e'(sew);
        vtype.vill = vill;
        req_addr   = addr;
        req_store  = wr;
        req_valid  = 1'b1;
        model(0, addr, vlv, sew, vill, wr, 256);
        model(1, addr, vlv, sew, vill, wr, 16);
        if (q0.size() == 0) due0 = 1'b1;
        if (q1.size() == 0) due1 = 1'b1;
        cycle();
        req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid0"}, 64'(av0), 64'd0);
        chk({tag, "_done0"}, 64'(dn0), 64'd0);
        chk({tag, "_busy0"}, 64'(bz0), 64'd0);
        chk({tag, "_addr0"}, aa0, 64'd0);
        chk({tag, "_len0"}, 64'(al0), 64'd0);
        chk({tag, "_last0"}, 64'(alst0), 64'd0);
        chk({tag, "_write0"}, 64'(aw0), 64'd0);
        chk({tag, "_valid1"}, 64'(av1), 64'd0);
        chk({tag, "_busy1"}, 64'(bz1), 64'd0);
        chk({tag, "_done1"}, 64'(dn1), 64'd0);
        chk({tag, "_addr1"}, aa1, 64'd0);
    endtask

    initial begin
        // Pin the model against hand-computed burst lists.
        model(0, 64'h0FC0, 64, 3, 1'b0, 1'b0, 256);
        chk("pin_pagesplit_n", 64'(q0.size()), 64'd2);
        chk("pin_pagesplit_a0", q0[0].addr, 64'h0FC0);
        chk("pin_pagesplit_l0", 64'(q0[0].len), 64'd0);
        chk("pin_pagesplit_t0", 64'(q0[0].last), 64'd0);
        chk("pin_pagesplit_a1", q0[1].addr, 64'h1000);
        chk("pin_pagesplit_l1", 64'(q0[1].len), 64'd6);
        chk("pin_pagesplit_t1", 64'(q0[1].last), 64'd1);
        q0.delete();
        model(1, 64'h0, 512, 2, 1'b0, 1'b0, 16);
        chk("pin_max16_n", 64'(q1.size()), 64'd2);
        chk("pin_max16_l0", 64'(q1[0].len), 64'd15);
        chk("pin_max16_a1", q1[1].addr, 64'h400);
        chk("pin_max16_l1", 64'(q1[1].len), 64'd15);
        q1.delete();
        model(0, 64'h1010, 16, 2, 1'b0, 1'b0, 256);
        chk("pin_unaligned_l", 64'(q0[0].len), 64'd1);
        chk("pin_unaligned_t", 64'(q0[0].last), 64'd1);
        q0.delete();
        model(0, 64'h1000, 16, 2, 1'b1, 1'b0, 256);
        chk("pin_vill_n", 64'(q0.size()), 64'd0);
        q0.delete();

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_ni = 1'b1;
        cycle();

        do_req(64'h1000, 16, 2, 1'b0, 1'b0);
        do_req(64'h1010, 16, 2, 1'b0, 1'b1);
        do_req(64'h0FC0, 64, 3, 1'b0, 1'b0);
        force_ready = 1'b1;
        do_req(64'h0, 512, 2, 1'b0, 1'b1);
        force_ready = 1'b0;
        stall_left = 6;
        do_req(64'h0FC0, 64, 3, 1'b0, 1'b1);
        do_req(64'h2000, 16, 2, 1'b1, 1'b0);
        do_req(64'h2000, 0, 2, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_req({24'd0, 8'($urandom_range(0, 255)), 32'($urandom)},
                   ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 700),
                   $urandom_range(0, 3), ($urandom_range(0, 15) == 0), 1'($urandom));
        end

        // Reset in the middle of a long request: abandon without done.
        vl = vl_t'(600);
        vtype = '0;
        vtype.vsew = EW64;
        req_addr = 64'h3040;
        req_valid = 1'b1;
        model(0, 64'h3040, 600, 3, 1'b0, 1'b1, 256);
        model(1, 64'h3040, 600, 3, 1'b0, 1'b1, 16);
        req_store = 1'b1;
        cycle();
        req_valid = 1'b0;
        cycle();
        rst_ni = 1'b0;
        #1;
        chk_reset_vals("midrst");
        q0.delete();
        q1.delete();
        due0 = 1'b0;
        due1 = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("midrst_hold");
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) cycle();
        do_req(64'h5000, 40, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
